// File: rtl/dot_accum_if.sv
// Product-in / sum-out stream bundle for the dot_accum stage.
// The product side is driven by the multiplier and the sum side feeds downstream.
interface dot_accum_if #(
    parameter int ACC_W = 24
);
    logic [15:0]      prod;
    logic             prod_valid;
    logic             prod_ready;
    logic             clear;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;
    logic             overflow;
    logic [7:0]       term_cnt;

    modport master (
        output prod, prod_valid, clear, sum_ready,
        input  prod_ready, sum, sum_valid, overflow, term_cnt
    );

    modport slave (
        input  prod, prod_valid, clear, sum_ready,
        output prod_ready, sum, sum_valid, overflow, term_cnt
    );
endinterface

// File: rtl/dot_accum.sv
// Sums N_TERMS unsigned 16-bit products into a dot product.
// The result is held in a one-deep output register with backpressure.
module dot_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24
) (
    input  logic         clk,
    input  logic         rst,
    dot_accum_if.slave   bus
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [7:0]       term_cnt_q, term_cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             overflow_q, overflow_d;
    logic             sum_valid_q, sum_valid_d;

    logic             last_term;
    logic             prod_ready;
    logic             accept;
    logic [ACC_W:0]   add_full;

    assign last_term  = (term_cnt_q == 8'(N_TERMS - 1));
    // Only the final term has to wait for the output register to free up.
    assign prod_ready = !rst && !bus.clear && !(last_term && sum_valid_q && !bus.sum_ready);
    assign accept     = bus.prod_valid && prod_ready;
    assign add_full   = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, bus.prod};

    always_comb begin
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        term_cnt_d  = term_cnt_q;
        sum_d       = sum_q;
        overflow_d  = overflow_q;
        sum_valid_d = sum_valid_q;

        if (sum_valid_q && bus.sum_ready) begin
            sum_valid_d = 1'b0;
        end

        if (bus.clear) begin
            acc_d      = '0;
            acc_ovf_d  = 1'b0;
            term_cnt_d = '0;
        end else if (accept) begin
            if (last_term) begin
                sum_d       = add_full[ACC_W-1:0];
                overflow_d  = acc_ovf_q | add_full[ACC_W];
                sum_valid_d = 1'b1;
                acc_d       = '0;
                acc_ovf_d   = 1'b0;
                term_cnt_d  = '0;
            end else begin
                acc_d      = add_full[ACC_W-1:0];
                acc_ovf_d  = acc_ovf_q | add_full[ACC_W];
                term_cnt_d = term_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            term_cnt_q  <= '0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            term_cnt_q  <= term_cnt_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.sum        = sum_q;
    assign bus.overflow   = overflow_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.term_cnt   = term_cnt_q;
endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum: a 24-bit and a 17-bit instance share one stimulus.
module tb_dot_accum;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dot_accum_if #(.ACC_W(24)) bus   ();
    dot_accum_if #(.ACC_W(17)) bus17 ();

    dot_accum #(.N_TERMS(4), .ACC_W(24)) dut   (.clk(clk), .rst(rst), .bus(bus));
    dot_accum #(.N_TERMS(4), .ACC_W(17)) dut17 (.clk(clk), .rst(rst), .bus(bus17));

    assign bus17.prod       = bus.prod;
    assign bus17.prod_valid = bus.prod_valid;
    assign bus17.clear      = bus.clear;
    assign bus17.sum_ready  = bus.sum_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one product, confirm it is accepted, and advance past the edge.
    task automatic put(input logic [15:0] v);
        bus.prod       = v;
        bus.prod_valid = 1'b1;
        #1;
        chk("put_ready", 32'(bus.prod_ready), 32'd1);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // 1. reset with a product offered
        rst           = 1'b1;
        bus.prod      = 16'd99;
        bus.prod_valid = 1'b1;
        bus.clear     = 1'b0;
        bus.sum_ready = 1'b1;
        tick();
        chk("rst_ready", 32'(bus.prod_ready), 32'd0);
        tick();
        chk("rst_ready2", 32'(bus.prod_ready), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_term_cnt", 32'(bus.term_cnt), 32'd0);
        rst            = 1'b0;
        bus.prod_valid = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.prod_ready), 32'd1);

        // 2. basic dot product 15+8+4+48
        put(16'd15);
        chk("basic_cnt1", 32'(bus.term_cnt), 32'd1);
        put(16'd8);
        chk("basic_cnt2", 32'(bus.term_cnt), 32'd2);
        put(16'd4);
        chk("basic_cnt3", 32'(bus.term_cnt), 32'd3);
        chk("basic_sv_early", 32'(bus.sum_valid), 32'd0);
        put(16'd48);
        chk("basic_cnt0", 32'(bus.term_cnt), 32'd0);
        chk("basic_sv", 32'(bus.sum_valid), 32'd1);
        chk("basic_sum", 32'(bus.sum), 32'd75);
        chk("basic_ovf", 32'(bus.overflow), 32'd0);
        bus.prod_valid = 1'b0;
        tick();
        chk("basic_sv_pulse", 32'(bus.sum_valid), 32'd0);

        // 3. maximum products; 17-bit instance wraps
        for (int i = 0; i < 4; i++) put(16'd65025);
        chk("max_sum24", 32'(bus.sum), 32'd260100);
        chk("max_ovf24", 32'(bus.overflow), 32'd0);
        chk("max_sum17", 32'(bus17.sum), 32'd129028);
        chk("max_ovf17", 32'(bus17.overflow), 32'd1);
        chk("max_sv17", 32'(bus17.sum_valid), 32'd1);
        for (int i = 0; i < 4; i++) put(16'd1);
        chk("after_sum17", 32'(bus17.sum), 32'd4);
        chk("after_ovf17", 32'(bus17.overflow), 32'd0);
        chk("after_sum24", 32'(bus.sum), 32'd4);
        bus.prod_valid = 1'b0;
        tick();

        // 4. backpressure
        bus.sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(16'd1);
        chk("bp_sv1", 32'(bus.sum_valid), 32'd1);
        chk("bp_sum1", 32'(bus.sum), 32'd4);
        for (int i = 0; i < 3; i++) put(16'd1);
        chk("bp_cnt3", 32'(bus.term_cnt), 32'd3);
        chk("bp_sum_held", 32'(bus.sum), 32'd4);
        bus.prod       = 16'd1;
        bus.prod_valid = 1'b1;
        #1;
        chk("bp_stall_ready", 32'(bus.prod_ready), 32'd0);
        tick();
        chk("bp_stall_cnt", 32'(bus.term_cnt), 32'd3);
        chk("bp_stall_sv", 32'(bus.sum_valid), 32'd1);
        bus.sum_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.prod_ready), 32'd1);
        tick();
        bus.sum_ready  = 1'b0;
        bus.prod_valid = 1'b0;
        chk("bp_sv2", 32'(bus.sum_valid), 32'd1);
        chk("bp_sum2", 32'(bus.sum), 32'd4);
        chk("bp_cnt0", 32'(bus.term_cnt), 32'd0);
        bus.sum_ready = 1'b1;
        tick();
        chk("bp_drained", 32'(bus.sum_valid), 32'd0);

        // 5. clear while a sum of 20 is held
        bus.sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(16'd5);
        put(16'd10);
        put(16'd20);
        chk("clr_cnt2", 32'(bus.term_cnt), 32'd2);
        bus.prod  = 16'd7;
        bus.clear = 1'b1;
        #1;
        chk("clr_ready", 32'(bus.prod_ready), 32'd0);
        tick();
        bus.clear      = 1'b0;
        bus.prod_valid = 1'b0;
        chk("clr_cnt0", 32'(bus.term_cnt), 32'd0);
        chk("clr_held_sv", 32'(bus.sum_valid), 32'd1);
        chk("clr_held_sum", 32'(bus.sum), 32'd20);
        bus.sum_ready = 1'b1;
        tick();
        chk("clr_drained", 32'(bus.sum_valid), 32'd0);
        put(16'd1);
        put(16'd2);
        put(16'd3);
        put(16'd4);
        chk("clr_sum", 32'(bus.sum), 32'd10);
        chk("clr_sv", 32'(bus.sum_valid), 32'd1);
        bus.prod_valid = 1'b0;
        tick();

        // 6. reset mid-group
        put(16'd100);
        put(16'd200);
        put(16'd300);
        chk("mid_cnt3", 32'(bus.term_cnt), 32'd3);
        bus.prod_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(bus.term_cnt), 32'd0);
        chk("mid_rst_sv", 32'(bus.sum_valid), 32'd0);
        tick();
        chk("mid_no_sv", 32'(bus.sum_valid), 32'd0);
        for (int i = 0; i < 4; i++) put(16'd1);
        chk("mid_sum", 32'(bus.sum), 32'd4);
        chk("mid_sv", 32'(bus.sum_valid), 32'd1);
        bus.prod_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_accum.md
# dot_accum

Accumulator stage that sits directly downstream of the `vedic_8X8` multiplier. It consumes the multiplier's 16-bit product `c` through a valid/ready handshake and sums `N_TERMS` consecutive products into a dot-product result. The completed sum is presented on a one-deep, backpressurable output register. Accumulation of the next group continues while a finished sum waits to be consumed.

## Interface
Parameters:
- `N_TERMS`, default 4: products per dot product; legal range 1..255.
- `ACC_W`, default 24: accumulator and output width; legal range 16..32.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `prod`, in, 16: product from the multiplier (unsigned).
- `prod_valid`, in, 1: `prod` is valid.
- `prod_ready`, out, 1: block accepts `prod` this cycle.
- `clear`, in, 1: abort the current group.
- `sum`, out, `ACC_W`: completed dot product.
- `sum_valid`, out, 1: `sum` is valid.
- `sum_ready`, in, 1: downstream consumes `sum`.
- `overflow`, out, 1: carry out of `ACC_W` bits occurred within the group reported on `sum`.
- `term_cnt`, out, 8: terms accepted in the current (incomplete) group.

## Operation
- Accept happens when `prod_valid && prod_ready` at a rising edge.
- Internal state:
  - `acc` (`ACC_W` bits)
  - `acc_ovf` (1 bit)
  - `term_cnt`
  - output register `sum`/`overflow`/`sum_valid`
- Non-final accept (`term_cnt < N_TERMS-1`):
  - `acc <= acc + zero_extend(prod)`, modulo 2^`ACC_W`.
  - `acc_ovf |=` carry out.
  - `term_cnt++`.
- Final accept (`term_cnt == N_TERMS-1`):
  - `sum <= acc + prod`.
  - `overflow <= acc_ovf | carry`.
  - `sum_valid <= 1`.
  - `acc`, `acc_ovf` and `term_cnt` return to 0.
- With `N_TERMS == 1`, every accept is a final accept.
- Output drain: `sum_valid && sum_ready` clears `sum_valid` at the edge. `sum` and `overflow` hold their last value.
- Simultaneous final accept and drain in the same cycle: the new sum loads and `sum_valid` stays 1 (no bubble).
- `prod_ready = !rst && !clear && !(term_cnt == N_TERMS-1 && sum_valid && !sum_ready)`.
  - This is combinational from `sum_ready`, `clear`, `rst` and registered state only.
  - Non-final terms are always accepted, even while the output is stalled.
- `clear`:
  - Zeroes `acc`, `acc_ovf` and `term_cnt` at the edge.
  - A product offered in the same cycle is not accepted (`prod_ready` is 0).
  - The output register and `sum_valid` are unaffected.
- Reset mid-group discards the partial sum. Reset with `sum_valid` high discards the held sum.

## Timing
- Reset values: `sum` 0, `sum_valid` 0, `overflow` 0, `term_cnt` 0. Internally, `acc` 0 and `acc_ovf` 0.
- `prod_ready` is 0 while `rst` is high and becomes 1 in the first cycle after `rst` falls.
- Latency: `sum_valid` rises 1 cycle after the final accept.
- Throughput: one product per cycle. A group of `N_TERMS` back-to-back accepts produces one sum every `N_TERMS` cycles with `sum_ready` held at 1.
- Stall: when the final term of group k+1 is offered while sum k is still held, `prod_ready` is 0 until `sum_ready` is 1. That term is then accepted in the same cycle sum k drains.
- `sum_valid` stays high with `sum` stable until drained; `sum` never changes while `sum_valid && !sum_ready`.
- `term_cnt` updates at the edge of each accept, clear, or reset.

## Test plan
All scenarios use `N_TERMS=4`, `ACC_W=24` unless stated.

1. **Reset:** hold `rst` for 2 cycles with `prod_valid=1`, `prod=99`.
   - During reset: `prod_ready=0`; all outputs 0; no term counted.
   - After reset: `prod_ready=1`.
2. **Basic dot product:** products 15, 8, 4, 48 (5·3, 4·2, 2·2, 6·8) back-to-back, `sum_ready=1`.
   - `sum=75`, `overflow=0`.
   - `sum_valid` is a single-cycle pulse one cycle after the 4th accept.
   - `term_cnt` steps 1, 2, 3, 0.
3. **Maximum values and overflow:**
   - Four products of 65025 (255·255): `sum=260100`, `overflow=0`.
   - Repeat with `ACC_W=17`: `sum=129028`, `overflow=1`.
   - A following group of 1, 1, 1, 1 gives `sum=4`, `overflow=0`.
4. **Backpressure:** `sum_ready=0`; stream eight products of value 1.
   - First `sum=4` is held.
   - Next three terms are accepted; the 8th sees `prod_ready=0`.
   - Raise `sum_ready` for 1 cycle: the 8th term is accepted that cycle and the second `sum=4` appears the next cycle.
5. **Clear:** accept 10, 20; assert `clear` with `prod_valid=1`, `prod=7`; then accept 1, 2, 3, 4.
   - 7 is not accepted.
   - `sum=10`.
   - A sum held when `clear` was asserted is still delivered intact.
6. **Reset mid-group:** accept 100, 200, 300; pulse `rst`; then accept 1, 1, 1, 1.
   - `term_cnt=0` after reset.
   - `sum=4`.
   - No `sum_valid` appears for the aborted group.
